// File: rtl/nvram_upload_pkg.sv
// Shared system constants: HPS download/upload file indices and the
// NVRAM upload FSM state encoding.
package nvram_upload_pkg;

   localparam logic [7:0] DL_INDEX_PGROM      = 8'd0;
   localparam logic [7:0] DL_INDEX_CHROM      = 8'd1;
   localparam logic [7:0] DL_INDEX_PALROM     = 8'd2;
   localparam logic [7:0] DL_INDEX_SPRITEROM  = 8'd3;
   localparam logic [7:0] NVRAM_UPLOAD_INDEX  = 8'd4;

   localparam int unsigned NVRAM_ADDR_W  = 14;
   localparam int unsigned IOCTL_ADDR_W  = 17;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_READY,
      ST_READ,
      ST_LATCH,
      ST_RELEASE
   } nvram_state_t;

endpackage

// File: rtl/nvram_upload.sv
// Streams CPU work RAM back to the HPS during an ioctl upload session,
// stalling the CPU for the duration and tracking whether RAM changed since.
// SIZE must not exceed 16384 bytes.
module nvram_upload
   import nvram_upload_pkg::*;
#(
   parameter logic [7:0]  UPLOAD_INDEX = NVRAM_UPLOAD_INDEX,
   parameter int unsigned SIZE         = 16384
)(
   input  logic                     clk_24,
   input  logic                     reset,
   input  logic                     ioctl_upload,
   input  logic [7:0]               ioctl_index,
   input  logic                     ioctl_rd,
   input  logic [IOCTL_ADDR_W-1:0]  ioctl_addr,
   output logic [7:0]               ioctl_din,
   output logic                     ioctl_wait,
   output logic                     bus_req,
   input  logic                     bus_ack,
   output logic [NVRAM_ADDR_W-1:0]  mem_addr,
   output logic                     mem_rd,
   input  logic [7:0]               mem_data,
   input  logic                     cpu_wr_mon,
   output logic                     dirty,
   output logic                     busy,
   output logic                     done
);

   nvram_state_t r_state;
   nvram_state_t w_next;
   logic         w_in_range;
   logic         r_reached_ready;

   // State register
   always_ff @(posedge clk_24 or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic; a dropped upload always wins over a pending read
   always_comb begin
      w_next     = r_state;
      w_in_range = (ioctl_addr < IOCTL_ADDR_W'(SIZE));
      case (r_state)
         ST_IDLE:    if (ioctl_upload && (ioctl_index == UPLOAD_INDEX)) w_next = ST_ARB;
         ST_ARB:     if (!ioctl_upload) w_next = ST_RELEASE;
                     else if (bus_ack)  w_next = ST_READY;
         ST_READY:   if (!ioctl_upload) w_next = ST_RELEASE;
                     else if (ioctl_rd && w_in_range) w_next = ST_READ;
         ST_READ:    if (!ioctl_upload) w_next = ST_RELEASE;
                     else               w_next = ST_LATCH;
         ST_LATCH:   if (!ioctl_upload) w_next = ST_RELEASE;
                     else               w_next = ST_READY;
         ST_RELEASE: w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   // Outputs registered from the next state so they align with it
   always_ff @(posedge clk_24 or posedge reset) begin
      if (reset) begin
         bus_req    <= 1'b0;
         ioctl_wait <= 1'b0;
         mem_rd     <= 1'b0;
         mem_addr   <= '0;
         done       <= 1'b0;
         busy       <= 1'b0;
         ioctl_din  <= 8'h00;
      end else begin
         bus_req    <= (w_next == ST_ARB) || (w_next == ST_READY) ||
                       (w_next == ST_READ) || (w_next == ST_LATCH);
         ioctl_wait <= (w_next == ST_ARB) || (w_next == ST_READ) || (w_next == ST_LATCH);
         mem_rd     <= (w_next == ST_READ);
         mem_addr   <= (w_next == ST_READ) ? ioctl_addr[NVRAM_ADDR_W-1:0] : '0;
         done       <= (w_next == ST_RELEASE);
         busy       <= (w_next != ST_IDLE);
         if ((r_state == ST_READY) && ioctl_upload && ioctl_rd && !w_in_range)
            ioctl_din <= 8'hFF;
         else if ((r_state == ST_LATCH) && ioctl_upload)
            ioctl_din <= mem_data;
      end
   end

   // A session only counts as a completed upload once it reached READY
   always_ff @(posedge clk_24 or posedge reset) begin
      if (reset)                      r_reached_ready <= 1'b0;
      else if (r_state == ST_IDLE)    r_reached_ready <= 1'b0;
      else if (r_state == ST_READY)   r_reached_ready <= 1'b1;
   end

   // CPU writes set dirty and beat a simultaneous end-of-upload clear
   always_ff @(posedge clk_24 or posedge reset) begin
      if (reset)                                           dirty <= 1'b0;
      else if (cpu_wr_mon)                                 dirty <= 1'b1;
      else if ((r_state == ST_RELEASE) && r_reached_ready) dirty <= 1'b0;
   end

endmodule

// File: tb/tb_nvram_upload.sv
// Randomized self-checking bench for nvram_upload against a transaction-level model.
`timescale 1ns/1ps
module tb_nvram_upload;

   localparam int unsigned SIZE = 16384;

   logic        clk_24 = 1'b0;
   logic        reset;
   logic        ioctl_upload;
   logic [7:0]  ioctl_index;
   logic        ioctl_rd;
   logic [16:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic        bus_req;
   logic        bus_ack;
   logic [13:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_data;
   logic        cpu_wr_mon;
   logic        dirty;
   logic        busy;
   logic        done;

   logic [7:0]  ram [SIZE];
   int          ack_delay;
   int          ack_cnt;
   int          rd_cnt;
   int          done_cnt;
   int          addr_viol;
   int          n_checks;
   int          n_errors;
   bit          m_dirty;

   always #5 clk_24 = ~clk_24;

   nvram_upload #(.UPLOAD_INDEX(8'd4), .SIZE(SIZE)) dut (
      .clk_24(clk_24), .reset(reset), .ioctl_upload(ioctl_upload),
      .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
      .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .bus_req(bus_req),
      .bus_ack(bus_ack), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_data(mem_data), .cpu_wr_mon(cpu_wr_mon), .dirty(dirty),
      .busy(busy), .done(done)
   );

   // Synchronous work RAM: q follows the address one cycle later
   always @(posedge clk_24) mem_data <= ram[mem_addr];

   // CPU side: grants the bus ack_delay cycles after the request (0 = never)
   always @(posedge clk_24) begin
      if (reset || !bus_req) begin
         ack_cnt <= 0;
         bus_ack <= 1'b0;
      end else if (ack_delay > 0 && ack_cnt >= ack_delay - 1) begin
         bus_ack <= 1'b1;
      end else begin
         ack_cnt <= ack_cnt + 1;
      end
   end

   always @(posedge clk_24) begin
      if (mem_rd) rd_cnt <= rd_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (!reset && !mem_rd && mem_addr != 14'd0) addr_viol <= addr_viol + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_24);
      #1;
   endtask

   task automatic start_session(input logic [7:0] idx, input int dly);
      bit ok;
      ack_delay    = dly;
      ioctl_index  = idx;
      ioctl_upload = 1'b1;
      tick();
      check("arb_bus_req", 32'(bus_req), 32'd1);
      check("arb_wait", 32'(ioctl_wait), 32'd1);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus_req && !ioctl_wait) begin ok = 1'b1; break; end
         tick();
      end
      check("ready_reached", 32'(ok), 32'd1);
   endtask

   task automatic do_read(input logic [16:0] addr);
      int       r0;
      bit       in_rng;
      logic [7:0] exp;
      in_rng = (int'(addr) < SIZE);
      exp    = in_rng ? ram[int'(addr[13:0])] : 8'hFF;
      r0     = rd_cnt;
      ioctl_addr = addr;
      ioctl_rd   = 1'b1;
      tick();
      ioctl_rd   = 1'b0;
      if (!in_rng) begin
         check("oor_din", 32'(ioctl_din), 32'(exp));
         check("oor_wait", 32'(ioctl_wait), 32'd0);
         tick();
      end else begin
         check("rd_wait_n1", 32'(ioctl_wait), 32'd1);
         tick();
         check("rd_wait_n2", 32'(ioctl_wait), 32'd1);
         tick();
         check("rd_wait_n3", 32'(ioctl_wait), 32'd0);
         check("rd_din", 32'(ioctl_din), 32'(exp));
      end
      tick();
      check("rd_memcount", 32'(rd_cnt - r0), in_rng ? 32'd1 : 32'd0);
   endtask

   task automatic cpu_write();
      cpu_wr_mon = 1'b1;
      tick();
      cpu_wr_mon = 1'b0;
      m_dirty    = 1'b1;
   endtask

   task automatic end_session(input bit completed, input bit wr_in_release);
      int d0;
      bit seen;
      d0 = done_cnt;
      ioctl_upload = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done) begin seen = 1'b1; break; end
      end
      check("done_seen", 32'(seen), 32'd1);
      check("release_bus_req", 32'(bus_req), 32'd0);
      if (wr_in_release) cpu_wr_mon = 1'b1;
      tick();
      cpu_wr_mon = 1'b0;
      if (completed) m_dirty = 1'b0;
      if (wr_in_release) m_dirty = 1'b1;
      tick();
      check("done_once", 32'(done_cnt - d0), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("dirty_after", 32'(dirty), 32'(m_dirty));
   endtask

   initial begin
      int  r0;
      bit  seen;
      logic [7:0] din0;
      n_checks = 0; n_errors = 0; m_dirty = 1'b0;
      rd_cnt = 0; done_cnt = 0; addr_viol = 0; ack_delay = 2;
      reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0;
      ioctl_addr = '0; cpu_wr_mon = 1'b0;
      for (int i = 0; i < int'(SIZE); i++) ram[i] = 8'($urandom);
      ram[16'h0123] = 8'h5A;
      repeat (3) tick();
      check("rst_din", 32'(ioctl_din), 32'd0);
      check("rst_wait", 32'(ioctl_wait), 32'd0);
      check("rst_bus_req", 32'(bus_req), 32'd0);
      check("rst_mem_rd", 32'(mem_rd), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dirty", 32'(dirty), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick();

      // Wrong index never engages the bus
      r0 = rd_cnt; seen = 1'b0;
      ioctl_index = 8'd3; ioctl_upload = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         seen |= bus_req | busy | mem_rd;
      end
      check("idx3_quiet", 32'(seen), 32'd0);
      check("idx3_no_mem", 32'(rd_cnt - r0), 32'd0);
      ioctl_upload = 1'b0;
      tick();

      // Directed read, out-of-range read, din hold, completed upload clearing dirty
      cpu_write();
      check("dirty_before", 32'(dirty), 32'd1);
      start_session(8'd4, 2);
      do_read(17'h00123);
      din0 = ioctl_din;
      do_read(17'h04000);
      repeat (3) tick();
      check("din_hold", 32'(ioctl_din), 32'hFF);
      do_read(17'h00123);
      check("din_reread", 32'(ioctl_din), 32'(din0));
      end_session(1'b1, 1'b0);

      // Randomized sessions
      for (int s = 0; s < 6; s++) begin
         start_session(8'd4, int'($urandom_range(1, 4)));
         for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 3) == 0) cpu_write();
            if ($urandom_range(0, 3) == 0)
               do_read(17'($urandom_range(SIZE, 131071)));
            else
               do_read(17'($urandom_range(0, SIZE - 1)));
         end
         end_session(1'b1, (s % 2) == 1);
      end

      // Reads during arbitration are ignored
      r0 = rd_cnt;
      ack_delay = 4;
      ioctl_index = 8'd4; ioctl_upload = 1'b1;
      tick();
      ioctl_addr = 17'h00005; ioctl_rd = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      repeat (6) tick();
      check("arb_rd_ignored", 32'(rd_cnt - r0), 32'd0);
      end_session(1'b1, 1'b1);

      // Abort from ARB leaves dirty set
      check("dirty_pre_abort", 32'(dirty), 32'd1);
      start_session(8'd4, 2);
      end_session(1'b1, 1'b0);
      cpu_write();
      ack_delay = 0;
      ioctl_index = 8'd4; ioctl_upload = 1'b1;
      repeat (4) tick();
      check("arb_stall_req", 32'(bus_req), 32'd1);
      check("arb_stall_wait", 32'(ioctl_wait), 32'd1);
      end_session(1'b0, 1'b0);

      // Reset while in READ
      start_session(8'd4, 1);
      ioctl_addr = 17'h00123; ioctl_rd = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      check("read_mem_rd", 32'(mem_rd), 32'd1);
      r0 = done_cnt;
      reset = 1'b1;
      #1;
      check("rst_mid_bus_req", 32'(bus_req), 32'd0);
      check("rst_mid_mem_rd", 32'(mem_rd), 32'd0);
      check("rst_mid_wait", 32'(ioctl_wait), 32'd0);
      ioctl_upload = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      repeat (3) tick();
      check("rst_mid_no_done", 32'(done_cnt - r0), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("addr_zero_outside_read", 32'(addr_viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
